// File: rtl/display_timing_gen.sv
// Raster timing generator: registered sync/DE/strobes aligned with signed x/y, pause via i_enable.
// New timing waits in a one-deep pending slot and is swapped in only on the end-of-frame wrap.
module display_timing_gen #(
  parameter int X_BITS     = 13,
  parameter int Y_BITS     = 12,
  parameter int FRAME_BITS = 16,
  parameter int DEF_H_RES  = 640,
  parameter int DEF_H_FP   = 16,
  parameter int DEF_H_SYNC = 96,
  parameter int DEF_H_BP   = 48,
  parameter int DEF_V_RES  = 480,
  parameter int DEF_V_FP   = 10,
  parameter int DEF_V_SYNC = 2,
  parameter int DEF_V_BP   = 33,
  parameter int DEF_H_POL  = 0,
  parameter int DEF_V_POL  = 0
) (
  input  logic                           i_pixel_clk,
  input  logic                           i_reset_n,
  input  logic                           i_enable,
  input  logic                           i_cfg_valid,
  output logic                           o_cfg_ready,
  input  logic [4*(X_BITS-1)-1:0]        i_cfg_h,
  input  logic [4*(Y_BITS-1)-1:0]        i_cfg_v,
  input  logic [1:0]                     i_cfg_pol,
  output logic [2:0]                     o_hvesync,
  output logic signed [X_BITS-1:0]       o_x,
  output logic signed [Y_BITS-1:0]       o_y,
  output logic                           o_line_start,
  output logic                           o_frame_start,
  output logic [FRAME_BITS-1:0]          o_frame_count
);
  localparam int HW = X_BITS - 1;
  localparam int VW = Y_BITS - 1;

  // Field index within a packed config: 3 = res, 2 = fp, 1 = sync, 0 = bp.
  function automatic logic signed [X_BITS-1:0] hf(input logic [4*HW-1:0] c, input int i);
    return $signed({1'b0, c[i*HW +: HW]});
  endfunction

  function automatic logic signed [Y_BITS-1:0] vf(input logic [4*VW-1:0] c, input int i);
    return $signed({1'b0, c[i*VW +: VW]});
  endfunction

  function automatic logic signed [X_BITS-1:0] h_start_of(input logic [4*HW-1:0] c);
    return -(hf(c, 2) + hf(c, 1) + hf(c, 0));
  endfunction

  function automatic logic signed [Y_BITS-1:0] v_start_of(input logic [4*VW-1:0] c);
    return -(vf(c, 2) + vf(c, 1) + vf(c, 0));
  endfunction

  localparam logic [4*HW-1:0] DEF_CFG_H = {HW'(DEF_H_RES), HW'(DEF_H_FP), HW'(DEF_H_SYNC), HW'(DEF_H_BP)};
  localparam logic [4*VW-1:0] DEF_CFG_V = {VW'(DEF_V_RES), VW'(DEF_V_FP), VW'(DEF_V_SYNC), VW'(DEF_V_BP)};
  localparam logic [1:0]      DEF_POL   = {1'(DEF_V_POL), 1'(DEF_H_POL)};
  localparam logic signed [X_BITS-1:0] DEF_H_START = h_start_of(DEF_CFG_H);
  localparam logic signed [Y_BITS-1:0] DEF_V_START = v_start_of(DEF_CFG_V);
  localparam logic signed [X_BITS-1:0] X_ONE = 1;
  localparam logic signed [Y_BITS-1:0] Y_ONE = 1;

  logic [4*HW-1:0] cfg_h_q, cfg_h_d, pend_h_q, pend_h_d;
  logic [4*VW-1:0] cfg_v_q, cfg_v_d, pend_v_q, pend_v_d;
  logic [1:0]      cfg_pol_q, cfg_pol_d, pend_pol_q, pend_pol_d;
  logic            pend_vld_q, pend_vld_d;
  // nx/ny is the next pixel to be shown; x/y is the pixel currently on the outputs.
  logic signed [X_BITS-1:0] nx_q, nx_d, x_q, x_d, h_start;
  logic signed [Y_BITS-1:0] ny_q, ny_d, y_q, y_d, v_start;
  logic [2:0]               hvesync_q, hvesync_d;
  logic                     line_q, line_d, frame_q, frame_d;
  logic [FRAME_BITS-1:0]    fcnt_q, fcnt_d;
  logic                     h_last, v_last, apply, in_hs, in_vs;

  always_comb begin
    h_start = h_start_of(cfg_h_q);
    v_start = v_start_of(cfg_v_q);
    h_last  = (nx_q == hf(cfg_h_q, 3) - X_ONE);
    v_last  = (ny_q == vf(cfg_v_q, 3) - Y_ONE);
    apply   = i_enable && h_last && v_last && pend_vld_q;
    in_hs   = (nx_q >= -(hf(cfg_h_q, 0) + hf(cfg_h_q, 1))) && (nx_q < -hf(cfg_h_q, 0));
    in_vs   = (ny_q >= -(vf(cfg_v_q, 0) + vf(cfg_v_q, 1))) && (ny_q < -vf(cfg_v_q, 0));

    cfg_h_d    = cfg_h_q;
    cfg_v_d    = cfg_v_q;
    cfg_pol_d  = cfg_pol_q;
    pend_h_d   = pend_h_q;
    pend_v_d   = pend_v_q;
    pend_pol_d = pend_pol_q;
    pend_vld_d = pend_vld_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    x_d        = x_q;
    y_d        = y_q;
    hvesync_d  = {1'b0, ~cfg_pol_q[1], ~cfg_pol_q[0]};
    line_d     = 1'b0;
    frame_d    = 1'b0;
    fcnt_d     = fcnt_q;

    // Transfer needs an empty slot, so it can never coincide with an apply.
    if (i_cfg_valid && !pend_vld_q) begin
      pend_h_d   = i_cfg_h;
      pend_v_d   = i_cfg_v;
      pend_pol_d = i_cfg_pol;
      pend_vld_d = 1'b1;
    end

    if (i_enable) begin
      x_d       = nx_q;
      y_d       = ny_q;
      hvesync_d = {~nx_q[X_BITS-1] & ~ny_q[Y_BITS-1],
                   in_vs ? cfg_pol_q[1] : ~cfg_pol_q[1],
                   in_hs ? cfg_pol_q[0] : ~cfg_pol_q[0]};
      line_d    = (nx_q == h_start);
      frame_d   = (nx_q == h_start) && (ny_q == v_start);
      if (frame_d) begin
        fcnt_d = fcnt_q + FRAME_BITS'(1);
      end
      if (apply) begin
        cfg_h_d    = pend_h_q;
        cfg_v_d    = pend_v_q;
        cfg_pol_d  = pend_pol_q;
        pend_vld_d = 1'b0;
        nx_d       = h_start_of(pend_h_q);
        ny_d       = v_start_of(pend_v_q);
      end else if (h_last) begin
        nx_d = h_start;
        ny_d = v_last ? v_start : ny_q + Y_ONE;
      end else begin
        nx_d = nx_q + X_ONE;
      end
    end
  end

  always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cfg_h_q    <= DEF_CFG_H;
      cfg_v_q    <= DEF_CFG_V;
      cfg_pol_q  <= DEF_POL;
      pend_h_q   <= '0;
      pend_v_q   <= '0;
      pend_pol_q <= '0;
      pend_vld_q <= 1'b0;
      nx_q       <= DEF_H_START;
      ny_q       <= DEF_V_START;
      x_q        <= DEF_H_START;
      y_q        <= DEF_V_START;
      hvesync_q  <= {1'b0, ~DEF_POL[1], ~DEF_POL[0]};
      line_q     <= 1'b0;
      frame_q    <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      cfg_h_q    <= cfg_h_d;
      cfg_v_q    <= cfg_v_d;
      cfg_pol_q  <= cfg_pol_d;
      pend_h_q   <= pend_h_d;
      pend_v_q   <= pend_v_d;
      pend_pol_q <= pend_pol_d;
      pend_vld_q <= pend_vld_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hvesync_q  <= hvesync_d;
      line_q     <= line_d;
      frame_q    <= frame_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign o_cfg_ready   = ~pend_vld_q;
  assign o_hvesync     = hvesync_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = line_q;
  assign o_frame_start = frame_q;
  assign o_frame_count = fcnt_q;
endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
- Parametrised successor to the fixed-mode pixel timing generator.
- Produces hsync, vsync and display-enable, plus signed x/y coordinates. Coordinates are negative in blanking and nonnegative in the visible area.
- Timing is runtime-reconfigurable through a valid/ready config port. A new config is applied only on a frame boundary, so there are no torn frames.
- Adds an enable/pause input, line-start and frame-start strobes, and a frame counter. Sits between the pixel clock domain and the scanout/pixel pipeline.

Parameters:
- X_BITS, 13, width of signed x coordinate and of horizontal timing fields
- Y_BITS, 12, width of signed y coordinate and of vertical timing fields
- FRAME_BITS, 16, width of frame counter
- DEF_H_RES / DEF_H_FP / DEF_H_SYNC / DEF_H_BP, 640/16/96/48, reset horizontal timing
- DEF_V_RES / DEF_V_FP / DEF_V_SYNC / DEF_V_BP, 480/10/2/33, reset vertical timing
- DEF_H_POL / DEF_V_POL, 0/0, reset sync polarity (0 = negative, 1 = positive)

Ports:
- i_pixel_clk  in  1  pixel clock
- i_reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  run when high; pause when low
- i_cfg_valid  in  1  new config offered
- o_cfg_ready  out  1  config slot free
- i_cfg_h  in  4*(X_BITS-1)  {h_res, h_fp, h_sync, h_bp}, unsigned
- i_cfg_v  in  4*(Y_BITS-1)  {v_res, v_fp, v_sync, v_bp}, unsigned
- i_cfg_pol  in  2  {v_pol, h_pol}
- o_hvesync  out  3  {display_enable, vsync, hsync}
- o_x  out  X_BITS signed  current x
- o_y  out  Y_BITS signed  current y
- o_line_start  out  1  one-cycle strobe at x == H_START
- o_frame_start  out  1  one-cycle strobe at (x, y) == (H_START, V_START)
- o_frame_count  out  FRAME_BITS  frames started since reset, wraps

Behaviour:
- Active config, horizontal: H_START = -(fp+sync+bp); sync region is [-(bp+sync), -bp); active region is [0, h_res-1]. Vertical uses the same structure.
- All computations use sign-extended X_BITS/Y_BITS arithmetic.
- Alignment (new vs. predecessor): o_hvesync, o_line_start and o_frame_start are registered and describe the same pixel as o_x/o_y in the same cycle. There is no one-cycle lag.
- Output decode:
  - display_enable = (x>=0 && y>=0).
  - hsync = h_pol when in hsync region, else ~h_pol. vsync is decoded the same way from v_pol.
- Reset (async assert, sync release):
  - Active config = DEF_*. Pending slot is empty, so o_cfg_ready = 1.
  - o_x = DEF H_START, o_y = DEF V_START.
  - o_hvesync = {0, ~DEF_V_POL, ~DEF_H_POL}.
  - Strobes = 0, o_frame_count = 0.
- The first enabled cycle after reset shows (H_START, V_START) with o_frame_start = 1 and o_frame_count = 1.
- Counting (i_enable = 1, each cycle):
  - If x == h_res-1: x <= H_START; y <= (y == v_res-1) ? V_START : y+1.
  - Otherwise: x <= x+1.
- Pause (i_enable = 0):
  - x, y and o_frame_count hold.
  - display_enable = 0, both syncs inactive, strobes = 0.
  - When i_enable returns high, counting resumes from the held position.
- Config handshake:
  - A transfer occurs when i_cfg_valid && o_cfg_ready. The transfer captures the config into the pending slot, and o_cfg_ready drops on the next cycle.
  - The pending config becomes active on the wrap from (h_res-1, v_res-1). x/y then start from the new H_START/V_START, and polarities switch on that same first pixel.
  - o_cfg_ready reasserts the cycle after the pending config is applied.
  - If a transfer and a wrap happen in the same cycle, the transfer lands in pending and is applied at the next wrap, not this one.
  - Without a valid pending config, the active config is unchanged forever.
- Illegal configs: res = 0 or sync = 0 is out of contract. fp or bp = 0 is legal, and the boundaries then coincide.
- Reset mid-frame or mid-handshake: pending config is discarded and the DEF_* config is restored.

Test Plan:
- Defaults, enable held high for 2 frames:
  - Line = 800 clocks, x runs -160..639; frame = 525 lines, y runs -45..479.
  - hsync = 0 exactly on x in [-144, -48); vsync = 0 on y in [-35, -33).
  - display_enable active for 640 x 480 pixels per frame; o_frame_count = 1 then 2.
- Alignment check: at every cycle, o_hvesync[2] == (o_x>=0 && o_y>=0). o_line_start is high exactly when o_x == -160.
- Mode switch to 1280x720 (fp/sync/bp 110/40/220, 5/5/20, pol 1/1), offered mid-frame:
  - o_cfg_ready drops; the current 640x480 frame completes unchanged.
  - Next frame starts at (-370, -30) with o_frame_start = 1; hsync = 1 on x in [-260, -220).
  - o_cfg_ready = 1 one cycle after the switch.
- Transfer on the exact wrap cycle: the old config runs one more full frame, and the new config applies at the following wrap.
- Pause of 37 cycles mid-line at x = 100: coordinates are frozen, display_enable = 0, syncs inactive. Counting resumes at x = 101.
- Async reset pulse mid-frame with a config pending: outputs take their reset values immediately, pending is dropped, and the DEF timing restarts.
